// File: rtl/if_fetch_stage_if.sv
// Fetch-to-decode handshake bundle: one instruction entry with its PC,
// next PC and an out-of-range flag, qualified by valid/ready.
interface if_fetch_stage_if;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_npc;
   logic        if_err;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      output if_npc,
      output if_err,
      input  id_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  if_npc,
      input  if_err,
      output id_ready
   );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, combinational imem addressing,
// one-entry output register towards decode with redirect flush and fetch counter.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          IMEM_AW  = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_instr,
   if_fetch_stage_if.master   dec,
   output logic [31:0]        fetch_cnt
);

   localparam logic [31:0] IMEM_BYTES = 32'd4 << IMEM_AW;

   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_npc_q, if_npc_d;
   logic        if_err_q, if_err_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic [31:0] off;
   logic        in_range;
   logic        xfer;
   logic        load;

   // Offset wraps modulo 2^32, so PCs below RESET_PC land far out of range.
   assign off       = pc_q - RESET_PC;
   assign in_range  = (off < IMEM_BYTES);
   assign imem_addr = off[IMEM_AW+1:2];

   assign xfer = if_valid_q && dec.id_ready && !redirect_valid;
   assign load = fetch_en && !redirect_valid && (!if_valid_q || dec.id_ready);

   always_comb begin
      pc_d        = pc_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      if_npc_d    = if_npc_q;
      if_err_d    = if_err_q;
      fetch_cnt_d = fetch_cnt_q + {31'd0, xfer};

      if (redirect_valid) begin
         pc_d       = redirect_pc & 32'hFFFF_FFFC;
         if_valid_d = 1'b0;
      end else if (load) begin
         if_instr_d = in_range ? imem_instr : 32'h0000_0000;
         if_err_d   = !in_range;
         if_pc_d    = pc_q;
         if_npc_d   = pc_q + 32'd4;
         if_valid_d = 1'b1;
         pc_d       = pc_q + 32'd4;
      end else if (xfer) begin
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         if_valid_q  <= 1'b0;
         if_instr_q  <= 32'd0;
         if_pc_q     <= 32'd0;
         if_npc_q    <= 32'd0;
         if_err_q    <= 1'b0;
         fetch_cnt_q <= 32'd0;
      end else begin
         pc_q        <= pc_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         if_npc_q    <= if_npc_d;
         if_err_q    <= if_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign dec.if_valid = if_valid_q;
   assign dec.if_instr = if_instr_q;
   assign dec.if_pc    = if_pc_q;
   assign dec.if_npc   = if_npc_q;
   assign dec.if_err   = if_err_q;
   assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, async-reset sequence and a
// randomized run checked through an expected-entry scoreboard queue.
module tb_if_fetch_stage;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] fetch_cnt;

   if_fetch_stage_if dec_if ();

   if_fetch_stage #(.RESET_PC(RPC), .IMEM_AW(11)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .dec            (dec_if),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Memory word k holds 0x1000_0000 + k
   assign imem_instr = 32'h1000_0000 + {21'd0, imem_addr};

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   typedef struct {
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_err;
      logic [31:0] e_cnt;
      logic [10:0] e_addr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } entry_t;

   vec_t   vecs [17];
   entry_t sb_q [$];

   function automatic entry_t model_fetch(input logic [31:0] pc);
      entry_t      e;
      logic [31:0] o;
      o        = pc - RPC;
      e.pc     = pc;
      e.err    = !(o < 32'h0000_2000);
      e.instr  = e.err ? 32'h0 : (32'h1000_0000 + {21'd0, o[12:2]});
      return e;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] mpc;
      logic        mvalid;
      logic [31:0] mcnt;
      logic [31:0] moff;
      logic        m_load, m_xfer;
      entry_t      e;

      //             fe    rdy   rv    rpc            valid pc             instr          err   cnt    addr
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 32'h1000_0000, 1'b0, 32'd0, 11'h001};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0004, 32'h1000_0001, 1'b0, 32'd1, 11'h002};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h1000_0002, 1'b0, 32'd2, 11'h003};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h1000_0002, 1'b0, 32'd2, 11'h003};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h1000_0002, 1'b0, 32'd2, 11'h003};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h1000_0002, 1'b0, 32'd2, 11'h003};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_000C, 32'h1000_0003, 1'b0, 32'd3, 11'h004};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h0040_0103, 1'b0, 32'h0040_000C, 32'h1000_0003, 1'b0, 32'd3, 11'h040};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0100, 32'h1000_0040, 1'b0, 32'd3, 11'h041};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0100, 32'h1000_0040, 1'b0, 32'd4, 11'h041};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0100, 32'h1000_0040, 1'b0, 32'd4, 11'h041};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0104, 32'h1000_0041, 1'b0, 32'd4, 11'h042};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0040_1FFC, 1'b0, 32'h0040_0104, 32'h1000_0041, 1'b0, 32'd4, 11'h7FF};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_1FFC, 32'h1000_07FF, 1'b0, 32'd4, 11'h000};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_2000, 32'h0000_0000, 1'b1, 32'd5, 11'h001};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_2004, 32'h0000_0000, 1'b1, 32'd6, 11'h002};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_2004, 32'h0000_0000, 1'b1, 32'd7, 11'h002};

      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      dec_if.id_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, dec_if.if_valid}, 32'd0);
      chk("rst_instr", dec_if.if_instr, 32'd0);
      chk("rst_pc", dec_if.if_pc, 32'd0);
      chk("rst_npc", dec_if.if_npc, 32'd0);
      chk("rst_err", {31'd0, dec_if.if_err}, 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      chk("rst_addr", {21'd0, imem_addr}, 32'd0);
      rst_n = 1'b1;

      // Directed table: inputs held over one edge, outputs checked just after it
      for (int i = 0; i < 17; i++) begin
         fetch_en        = vecs[i].fe;
         dec_if.id_ready = vecs[i].rdy;
         redirect_valid  = vecs[i].rv;
         redirect_pc     = vecs[i].rpc;
         @(posedge clk);
         #1;
         $display("vec %0d: valid=%b pc=%h instr=%h err=%b cnt=%0d addr=%h", i,
                  dec_if.if_valid, dec_if.if_pc, dec_if.if_instr, dec_if.if_err, fetch_cnt, imem_addr);
         chk($sformatf("v%0d_valid", i), {31'd0, dec_if.if_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_pc", i), dec_if.if_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_npc", i), dec_if.if_npc, vecs[i].e_pc + 32'd4);
         chk($sformatf("v%0d_instr", i), dec_if.if_instr, vecs[i].e_instr);
         chk($sformatf("v%0d_err", i), {31'd0, dec_if.if_err}, {31'd0, vecs[i].e_err});
         chk($sformatf("v%0d_cnt", i), fetch_cnt, vecs[i].e_cnt);
         chk($sformatf("v%0d_addr", i), {21'd0, imem_addr}, {21'd0, vecs[i].e_addr});
         @(negedge clk);
      end

      // Asynchronous reset between edges while an entry is pending
      redirect_valid  = 1'b0;
      fetch_en        = 1'b1;
      dec_if.id_ready = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, dec_if.if_valid}, 32'd0);
      chk("arst_pc", dec_if.if_pc, 32'd0);
      chk("arst_instr", dec_if.if_instr, 32'd0);
      chk("arst_cnt", fetch_cnt, 32'd0);
      chk("arst_addr", {21'd0, imem_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("restart: valid=%b pc=%h instr=%h", dec_if.if_valid, dec_if.if_pc, dec_if.if_instr);
      chk("restart_valid", {31'd0, dec_if.if_valid}, 32'd1);
      chk("restart_pc", dec_if.if_pc, RPC);
      chk("restart_instr", dec_if.if_instr, 32'h1000_0000);

      // Randomized stream against a scoreboard of expected entries
      sb_q.push_back(model_fetch(RPC));
      mpc    = RPC + 32'd4;
      mvalid = 1'b1;
      mcnt   = 32'd0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         fetch_en        = ($urandom_range(0, 3) != 0);
         dec_if.id_ready = ($urandom_range(0, 3) != 0);
         redirect_valid  = ($urandom_range(0, 15) == 0);
         redirect_pc     = RPC + $urandom_range(0, 32'h2100);
         #1;
         moff = mpc - RPC;
         chk("sb_valid", {31'd0, dec_if.if_valid}, {31'd0, mvalid});
         chk("sb_addr", {21'd0, imem_addr}, {21'd0, moff[12:2]});
         if (dec_if.if_valid && dec_if.id_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow actual=transfer required=no_entry pc=%h", dec_if.if_pc);
            end else begin
               e = sb_q.pop_front();
               $display("xfer: pc=%h instr=%h err=%b", dec_if.if_pc, dec_if.if_instr, dec_if.if_err);
               chk("sb_pc", dec_if.if_pc, e.pc);
               chk("sb_npc", dec_if.if_npc, e.pc + 32'd4);
               chk("sb_instr", dec_if.if_instr, e.instr);
               chk("sb_err", {31'd0, dec_if.if_err}, {31'd0, e.err});
            end
         end else if (redirect_valid && sb_q.size() != 0) begin
            void'(sb_q.pop_front());
         end
         m_xfer = mvalid && dec_if.id_ready && !redirect_valid;
         m_load = fetch_en && !redirect_valid && (!mvalid || dec_if.id_ready);
         if (m_load) sb_q.push_back(model_fetch(mpc));
         mcnt = mcnt + {31'd0, m_xfer};
         if (redirect_valid) begin
            mpc    = redirect_pc & 32'hFFFF_FFFC;
            mvalid = 1'b0;
         end else if (m_load) begin
            mvalid = 1'b1;
            mpc    = mpc + 32'd4;
         end else if (m_xfer) begin
            mvalid = 1'b0;
         end
      end
      @(negedge clk);
      chk("sb_cnt", fetch_cnt, mcnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
